// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: column FrameData/FrameStrobe write sequencer with setup/strobe/hold timing.
// Optional FRAME_STROBE_COUNT_EN adds a completed-write counter (frame_count, count_clr).
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int FrameAddrWidth  = 5,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1,
  parameter int HoldCycles      = 1
) (
  input  logic                       UserCLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [FrameAddrWidth-1:0]  cmd_frame,
  input  logic [FrameBitsPerRow-1:0] cmd_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       err_clr
`ifdef FRAME_STROBE_COUNT_EN
  ,
  input  logic                       count_clr,
  output logic [15:0]                frame_count
`endif
);
  localparam logic [FrameAddrWidth:0]  LP_MAX    = (FrameAddrWidth+1)'(MaxFramesPerCol);
  localparam logic [7:0]               LP_SETUP  = 8'(SetupCycles - 1);
  localparam logic [7:0]               LP_STROBE = 8'(StrobeCycles - 1);
  localparam logic [7:0]               LP_HOLD   = 8'(HoldCycles - 1);
  localparam logic [MaxFramesPerCol-1:0] LP_ONE  = MaxFramesPerCol'(1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt, w_cnt;
  logic [FrameAddrWidth-1:0] r_idx;
  logic w_acc, w_ok, w_zero;
  assign w_acc  = cmd_valid && cmd_ready;
  assign w_ok   = {1'b0, cmd_frame} < LP_MAX;
  assign w_zero = r_cnt == 8'd0;
  always_ff @(posedge UserCLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_cnt  = w_zero ? r_cnt : r_cnt - 8'd1;
    case (r_state)
      IDLE:    if (w_acc && w_ok) begin w_next = SETUP;  w_cnt = LP_SETUP;  end
      SETUP:   if (w_zero)        begin w_next = STROBE; w_cnt = LP_STROBE; end
      STROBE:  if (w_zero)        begin w_next = HOLD;   w_cnt = LP_HOLD;   end
      default: if (w_zero)        w_next = IDLE;
    endcase
  end
  // Strobe register has async reset so the line drops the instant RST rises.
  always_ff @(posedge UserCLK or posedge RST)
    if (RST) begin
      r_cnt       <= 8'd0;
      r_idx       <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_cnt       <= w_cnt;
      cmd_ready   <= w_next == IDLE;
      busy        <= w_next != IDLE;
      done        <= r_state == HOLD && w_next == IDLE;
      FrameStrobe <= w_next == STROBE ? LP_ONE << r_idx : '0;
      err         <= (w_acc && !w_ok) || (err && !err_clr);
      if (w_acc && w_ok) begin
        FrameData <= cmd_data;
        r_idx     <= cmd_frame;
      end
    end
`ifdef FRAME_STROBE_COUNT_EN
  always_ff @(posedge UserCLK or posedge RST)
    if (RST) frame_count <= 16'd0;
    else frame_count <= count_clr ? 16'd0 : frame_count + {15'd0, done};
`endif
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb_frame_strobe_sequencer: scoreboard bench; DUT a uses 1/1/1 timing, DUT b uses 3/2/4.
module tb_frame_strobe_sequencer;
  logic clk, rst;
  logic a_valid, a_ready, a_busy, a_done, a_err, a_clr;
  logic [4:0] a_frame;
  logic [31:0] a_data, a_fd;
  logic [19:0] a_fs;
  logic b_valid, b_ready, b_busy, b_done, b_err;
  logic [4:0] b_frame;
  logic [31:0] b_data, b_fd;
  logic [19:0] b_fs;
`ifdef FRAME_STROBE_COUNT_EN
  logic a_cclr;
  logic [15:0] a_cnt, b_cnt;
`endif
  typedef struct {logic [19:0] vec; logic [31:0] dat;} exp_t;
  exp_t sb_q[$];
  int n_chk = 0, n_pass = 0;
  frame_strobe_sequencer u_a (
    .UserCLK(clk), .RST(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_frame(a_frame), .cmd_data(a_data), .FrameData(a_fd), .FrameStrobe(a_fs),
    .busy(a_busy), .done(a_done), .err(a_err), .err_clr(a_clr)
`ifdef FRAME_STROBE_COUNT_EN
    , .count_clr(a_cclr), .frame_count(a_cnt)
`endif
  );
  frame_strobe_sequencer #(.SetupCycles(3), .StrobeCycles(2), .HoldCycles(4)) u_b (
    .UserCLK(clk), .RST(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_frame(b_frame), .cmd_data(b_data), .FrameData(b_fd), .FrameStrobe(b_fs),
    .busy(b_busy), .done(b_done), .err(b_err), .err_clr(1'b0)
`ifdef FRAME_STROBE_COUNT_EN
    , .count_clr(1'b0), .frame_count(b_cnt)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push_a(input logic [4:0] f, input logic [31:0] d);
    exp_t e;
    a_frame = f;
    a_data  = d;
    e.vec = 20'd1 << f;
    e.dat = d;
    sb_q.push_back(e);
  endtask
  // Monitor for DUT a: one-hot, strobe length, low gap between strobes, scoreboard pop on done.
  initial begin
    int run, gap, last_len;
    bit seen;
    logic [19:0] s_vec;
    exp_t e;
    run = 0; gap = 0; last_len = 0; seen = 0; s_vec = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; seen = 0; gap = 0;
      end else begin
        if (a_fs != 0) begin
          chk("onehot", 64'($onehot(a_fs)), 1);
          if (run == 0 && seen) chk("gap_ge2", 64'(gap >= 2), 1);
          s_vec = a_fs;
          run++;
        end else begin
          if (run > 0) begin last_len = run; run = 0; seen = 1; gap = 0; end
          gap++;
        end
        if (a_done) begin
          if (sb_q.size() == 0) chk("done_unexp", 1, 0);
          else begin
            e = sb_q.pop_front();
            chk("sb_strobe", 64'(s_vec), 64'(e.vec));
            chk("sb_data", 64'(a_fd), 64'(e.dat));
            chk("sb_len", 64'(last_len), 1);
          end
        end
      end
    end
  end
  initial begin
    int bi, busy_n, str_n, first_k, done_n, done_k;
    bit fin, rdy;
    rst = 1; a_valid = 0; a_frame = 0; a_data = 0; a_clr = 0;
    b_valid = 0; b_frame = 0; b_data = 0;
`ifdef FRAME_STROBE_COUNT_EN
    a_cclr = 0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(a_ready), 1);
    chk("rst_busy", 64'(a_busy), 0);
    chk("rst_done", 64'(a_done), 0);
    chk("rst_err", 64'(a_err), 0);
    chk("rst_fs", 64'(a_fs), 0);
    chk("rst_fd", 64'(a_fd), 0);
    rst = 0;
    step;
    // basic write, 1/1/1
    a_valid = 1;
    push_a(5'd3, 32'hA5A5_0F0F);
    step;
    a_valid = 0;
    chk("t1_fd", 64'(a_fd), 64'h A5A5_0F0F);
    chk("t1_setup_fs", 64'(a_fs), 0);
    chk("t1_busy", 64'(a_busy), 1);
    chk("t1_ready", 64'(a_ready), 0);
    step;
    chk("t1_strobe", 64'(a_fs), 64'h8);
    step;
    chk("t1_hold_fs", 64'(a_fs), 0);
    chk("t1_hold_done", 64'(a_done), 0);
    step;
    chk("t1_done", 64'(a_done), 1);
    chk("t1_done_ready", 64'(a_ready), 1);
    chk("t1_done_busy", 64'(a_busy), 0);
    step;
    chk("t1_done_pulse", 64'(a_done), 0);
    // timing 3/2/4, frame 19
    b_valid = 1; b_frame = 5'd19; b_data = 32'hDEAD_BEEF;
    step;
    b_valid = 0;
    busy_n = 0; str_n = 0; first_k = -1; done_n = 0; done_k = -1;
    for (int k = 0; k < 12; k++) begin
      if (b_busy) busy_n++;
      if (b_fs != 0) begin
        chk("t2_strobe_val", 64'(b_fs), 64'h80000);
        str_n++;
        if (first_k < 0) first_k = k;
      end
      if (b_done) begin done_n++; done_k = k; end
      step;
    end
    chk("t2_busy_cycles", 64'(busy_n), 9);
    chk("t2_strobe_cycles", 64'(str_n), 2);
    chk("t2_strobe_latency", 64'(first_k), 3);
    chk("t2_done_count", 64'(done_n), 1);
    chk("t2_done_when", 64'(done_k), 9);
    chk("t2_fd", 64'(b_fd), 64'hDEAD_BEEF);
    // out-of-range
    a_valid = 1; a_frame = 5'd20; a_data = 32'h1234_5678;
    step;
    chk("oor20_err", 64'(a_err), 1);
    chk("oor20_ready", 64'(a_ready), 1);
    chk("oor20_busy", 64'(a_busy), 0);
    chk("oor20_fd", 64'(a_fd), 64'hA5A5_0F0F);
    a_frame = 5'd31;
    step;
    chk("oor31_err", 64'(a_err), 1);
    chk("oor31_ready", 64'(a_ready), 1);
    a_valid = 0;
    step;
    chk("oor_fs", 64'(a_fs), 0);
    chk("oor_no_done", 64'(a_done), 0);
    a_clr = 1;
    step;
    a_clr = 0;
    chk("errclr", 64'(a_err), 0);
    a_clr = 1; a_valid = 1; a_frame = 5'd25;
    step;
    chk("errclr_set_wins", 64'(a_err), 1);
    a_valid = 0;
    step;
    chk("errclr_again", 64'(a_err), 0);
    a_clr = 0;
    // back-to-back
    bi = 0; fin = 0;
    a_valid = 1;
    push_a(5'd0, 32'h1111_0000);
    for (int c = 0; c < 40 && !fin; c++) begin
      rdy = a_ready;
      if (rdy && bi > 0) chk("b2b_on_done", 64'(a_done), 1);
      step;
      if (rdy) begin
        bi++;
        if (bi == 3) begin a_valid = 0; fin = 1; end
        else push_a(5'(bi), 32'h1111_0000 + 32'(bi));
      end
    end
    chk("b2b_accepts", 64'(bi), 3);
    a_valid = 0;
    for (int c = 0; c < 6; c++) step;
    chk("sb_empty", 64'(sb_q.size()), 0);
    // async reset mid-strobe on b
    b_valid = 1; b_frame = 5'd7; b_data = 32'h0BAD_F00D;
    step;
    b_valid = 0;
    fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      if (b_fs != 0) fin = 1;
      else step;
    end
    chk("rst_wait_strobe", 64'(fin), 1);
    step;
    chk("rst_strobe_2nd", 64'(b_fs), 64'h80);
    rst = 1;
    #1;
    chk("async_rst_fs", 64'(b_fs), 0);
    @(negedge clk);
    rst = 0;
    step;
    chk("post_rst_ready", 64'(b_ready), 1);
    chk("post_rst_busy", 64'(b_busy), 0);
    chk("post_rst_fd", 64'(b_fd), 0);
    chk("post_rst_err", 64'(b_err), 0);
    chk("post_rst_fs", 64'(b_fs), 0);
`ifdef FRAME_STROBE_COUNT_EN
    chk("cnt_rst", 64'(a_cnt), 0);
    for (int w = 0; w < 2; w++) begin
      a_valid = 1;
      push_a(5'd5, 32'h5555_0000 + 32'(w));
      step;
      a_valid = 0;
      fin = 0;
      for (int c = 0; c < 10 && !fin; c++) begin
        if (a_done) fin = 1;
        else step;
      end
      chk("cnt_wait_done", 64'(fin), 1);
      if (w == 1) a_cclr = 1;
      step;
      a_cclr = 0;
      chk(w == 0 ? "cnt_incr" : "cnt_clr_with_done", 64'(a_cnt), w == 0 ? 64'd1 : 64'd0);
    end
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
